// File: rtl/complete_arbiter.sv
// Completion arbiter in front of the ROB's single complete port: one buffer per unit,
// oldest-first issue relative to the ROB head, and branch-recovery hold/flush sequencing.
module complete_arbiter #(
  parameter int N_REQ = 3,
  parameter int ROB_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*ROB_W-1:0] req_rob,
  input  logic [N_REQ-1:0]       req_cf,
  input  logic [N_REQ*32-1:0]    req_addr,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [ROB_W-1:0]       rob_head,
  input  logic                   cf_done,
  output logic                   complete,
  output logic [ROB_W-1:0]       rob_number,
  output logic                   changeFlow,
  output logic [31:0]            jb_addr,
  output logic                   hold
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_nx;

  logic [N_REQ-1:0] v;
  logic [N_REQ-1:0] b_cf;
  logic [ROB_W-1:0] b_rob  [N_REQ];
  logic [31:0]      b_addr [N_REQ];
  logic [ROB_W-1:0] br_rob;

  logic [ROB_W-1:0] entry_age [N_REQ];
  logic [ROB_W-1:0] req_age   [N_REQ];

  logic             found;
  logic [ROB_W-1:0] best_age;
  logic [IDX_W-1:0] gsel;
  logic [N_REQ-1:0] grant;
  logic             enter_hold;
  logic             filter;
  logic [ROB_W-1:0] flush_age;

  // Ages wrap modulo 2^ROB_W, so head 14 makes ROB 15 older than ROB 1.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      entry_age[i] = b_rob[i] - rob_head;
      req_age[i]   = req_rob[i*ROB_W +: ROB_W] - rob_head;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    found      = 1'b0;
    best_age   = '0;
    gsel       = '0;
    grant      = '0;
    state_nx   = state;
    if (state == RUN) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (v[i] && (!found || entry_age[i] < best_age)) begin
          found    = 1'b1;
          best_age = entry_age[i];
          gsel     = IDX_W'(i);
        end
      end
    end
    if (found) grant[gsel] = 1'b1;

    enter_hold = found && b_cf[gsel];
    // Anything younger than the branch is squashed, both already buffered and newly arriving.
    filter     = (state == HOLD) || enter_hold;
    flush_age  = (state == HOLD) ? (br_rob - rob_head) : best_age;

    case (state)
      RUN:     if (enter_hold) state_nx = HOLD;
      HOLD:    if (cf_done)    state_nx = RUN;
      default: state_nx = RUN;
    endcase

    req_ready = ~v | grant;
  end

  assign hold = (state == HOLD);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  // NOTE: buffer payload is reset along with the valid bits so nothing unknown ever reaches the ROB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v      <= '0;
      b_cf   <= '0;
      br_rob <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        b_rob[i]  <= '0;
        b_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (filter && req_age[i] > flush_age) begin
            v[i] <= 1'b0;
          end else begin
            v[i]      <= 1'b1;
            b_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
            b_cf[i]   <= req_cf[i];
            b_addr[i] <= req_addr[i*32 +: 32];
          end
        end else if (grant[i] || (enter_hold && v[i] && entry_age[i] > best_age)) begin
          v[i] <= 1'b0;
        end
      end
      if (enter_hold) br_rob <= b_rob[gsel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      complete   <= 1'b0;
      changeFlow <= 1'b0;
      rob_number <= '0;
      jb_addr    <= '0;
    end else begin
      complete   <= found;
      changeFlow <= found && b_cf[gsel];
      if (found) begin
        rob_number <= b_rob[gsel];
        jb_addr    <= b_addr[gsel];
      end
    end
  end

endmodule
